// File: rtl/spectrum_framer.sv
// Turns streaming complex FFT output into per-bin power for bins 0..I-1, buffers one frame and
// replays it as a contiguous burst of I valid cycles once the consumer is ready.
module spectrum_framer #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned FFT_SIZE  = 1024,
  parameter int unsigned I         = 160
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       fft_in_valid,
  input  logic signed [IN_WIDTH-1:0] fft_in_re,
  input  logic signed [IN_WIDTH-1:0] fft_in_im,
  input  logic                       fft_in_last,
  input  logic                       consumer_ready,
  output logic                       fft_valid,
  output logic [BIT_WIDTH-1:0]       fft_data,
  output logic                       frame_dropped,
  output logic                       frame_error
);

  localparam int unsigned CW = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
  localparam int unsigned AW = (I > 1) ? $clog2(I) : 1;
  localparam int unsigned EW = $clog2(I + 1);
  localparam int unsigned SW = 2 * IN_WIDTH;
  localparam int unsigned PW = 2 * IN_WIDTH + 1;
  localparam logic [CW-1:0] LastIdx = CW'(FFT_SIZE - 1);
  localparam logic [EW-1:0] EmitEnd = EW'(I);

  typedef enum logic [2:0] {StSync, StArmed, StCapture, StHold, StEmit} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        emit_q, emit_d;
  logic                 at_boundary_q;
  logic [CW-1:0]        idx;
  logic                 is_end;
  logic                 capture;
  logic                 err_d, drop_d;
  logic                 rd_en;

  logic signed [SW-1:0] re_ext, im_ext;
  logic [SW-1:0]        s1_re_q, s1_im_q;
  logic [AW-1:0]        s1_addr_q, s2_addr_q;
  logic                 s1_vld_q, s2_vld_q;
  logic [PW-1:0]        sum;
  logic [BIT_WIDTH-1:0] pwr, s2_pwr_q;

  logic [BIT_WIDTH-1:0] mem_q [I];
  logic                 fft_valid_q, dropped_q, error_q;
  logic [BIT_WIDTH-1:0] fft_data_q;

  // In ARMED the incoming sample is bin 0 regardless of the counter.
  assign idx     = (state_q == StArmed) ? '0 : cnt_q;
  assign is_end  = (idx == LastIdx);
  assign capture = fft_in_valid && ((state_q == StArmed) || (state_q == StCapture)) &&
                   (32'(idx) < I);
  assign rd_en   = (state_q == StEmit) && (emit_q != EmitEnd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit_d  = emit_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StSync: begin
        if (fft_in_valid && fft_in_last) state_d = StArmed;
      end
      StArmed, StCapture: begin
        if (fft_in_valid) begin
          if (fft_in_last) begin
            cnt_d = '0;
            if (is_end) begin
              state_d = StHold;
            end else begin
              err_d   = 1'b1;
              state_d = StArmed;
            end
          end else begin
            state_d = StCapture;
            cnt_d   = is_end ? idx : idx + 1'b1;
          end
        end
      end
      StHold: begin
        drop_d = fft_in_valid && fft_in_last;
        // Leave only once the last buffer write has landed.
        if (consumer_ready && !s1_vld_q && !s2_vld_q) begin
          state_d = StEmit;
          emit_d  = '0;
        end
      end
      StEmit: begin
        drop_d = fft_in_valid && fft_in_last;
        if (emit_q == EmitEnd) begin
          state_d = (at_boundary_q && !fft_in_valid) ? StArmed : StSync;
        end else begin
          emit_d = emit_q + 1'b1;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= StSync;
      cnt_q         <= '0;
      emit_q        <= '0;
      at_boundary_q <= 1'b0;
      dropped_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      emit_q    <= emit_d;
      dropped_q <= drop_d;
      error_q   <= err_d;
      if (fft_in_valid) at_boundary_q <= fft_in_last;
    end
  end

  assign re_ext = SW'(fft_in_re);
  assign im_ext = SW'(fft_in_im);
  assign sum    = {1'b0, s1_re_q} + {1'b0, s1_im_q};

  generate
    if (BIT_WIDTH < PW) begin : g_sat
      assign pwr = (|sum[PW-1:BIT_WIDTH]) ? '1 : sum[BIT_WIDTH-1:0];
    end else begin : g_ext
      assign pwr = BIT_WIDTH'(sum);
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_vld_q  <= 1'b0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_pwr_q  <= '0;
      s2_addr_q <= '0;
    end else begin
      s1_vld_q <= capture;
      if (capture) begin
        s1_re_q   <= $unsigned(re_ext * re_ext);
        s1_im_q   <= $unsigned(im_ext * im_ext);
        s1_addr_q <= idx[AW-1:0];
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_pwr_q  <= pwr;
        s2_addr_q <= s1_addr_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (s2_vld_q) mem_q[s2_addr_q] <= s2_pwr_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fft_valid_q <= 1'b0;
      fft_data_q  <= '0;
    end else begin
      fft_valid_q <= rd_en;
      fft_data_q  <= rd_en ? mem_q[emit_q[AW-1:0]] : '0;
    end
  end

  assign fft_valid     = fft_valid_q;
  assign fft_data      = fft_data_q;
  assign frame_dropped = dropped_q;
  assign frame_error   = error_q;

endmodule
